uart_axil_slave: RTL and testbench

AXI4-Lite slave that bridges the system bus onto the UART register-file port (reg_addr/reg_wdata/reg_wen/reg_ren/reg_rdata/reg_error). It sits directly upstream of the register file and converts independent AW/W/AR channel handshakes into single-cycle register strobes. It returns B/R responses with OKAY/SLVERR status. It serialises reads and writes onto the one register port, using round-robin arbitration.

---
 rtl/uart_axil_if.sv | 38 +++
 rtl/uart_axil_slave.sv | 164 ++++++++++++++++
 tb/tb_uart_axil_slave.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axil_if.sv
// AXI4-Lite bus bundle between a bus master and uart_axil_slave.
// Holds the AW, W, B, AR and R channels. Clock and reset are not part of the bundle.
interface uart_axil_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/uart_axil_slave.sv
// AXI4-Lite slave bridging the bus onto the UART register-file port.
// Each of the AW, W and AR channels has a one-deep holding register.
// One FSM serialises writes and reads onto the single register port.
// When both a write and a read are pending, round-robin arbitration picks one.
//
// Handshake rule: a transfer on any channel happens on the rising uart_clk edge
// where both valid and ready are high. A valid, once raised, stays high with a
// stable payload until that edge.
//
// Optional build macro UART_AXIL_STRB_CHECK_EN: a legal-address write whose
// s_wstrb is not 4'hF is refused (no reg_wen) and answered with SLVERR.
// Without the macro, s_wstrb is ignored and every legal write is a full-word write.
module uart_axil_slave #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  uart_axil_if.slave            s,
  output logic [3:0]            reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_error,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state, state_next;
  logic                  aw_held, w_held, ar_held;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  last_rd;
  logic [1:0]            bresp, rresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_pend, rd_pend, wr_ok, rd_ok;

  // A register access must be word aligned and fall inside the 16-word window.
  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 6) == '0);
  endfunction

  assign wr_pend = aw_held & w_held;
  assign rd_pend = ar_held;
  assign rd_ok   = addr_legal(ar_addr);

`ifdef UART_AXIL_STRB_CHECK_EN
  logic [DATA_WIDTH/8-1:0] w_strb;
  // Keep the byte strobes of the held write so partial writes can be refused.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) w_strb <= '0;
    else if (s.s_wvalid && !w_held) w_strb <= s.s_wstrb;
  end
  assign wr_ok = addr_legal(aw_addr) && (&w_strb);
`else
  assign wr_ok = addr_legal(aw_addr);
`endif

  assign s.s_awready = !aw_held;
  assign s.s_wready  = !w_held;
  assign s.s_arready = !ar_held;
  assign s.s_bresp   = bresp;
  assign s.s_rresp   = rresp;
  assign s.s_rdata   = rdata;
  assign reg_wdata   = w_data;
  assign fsm_state   = state;

  // State register. Reset returns to IDLE, which drops both response valids at once.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic, register strobes and response valids.
  always_comb begin
    state_next = state;
    reg_wen    = 1'b0;
    reg_ren    = 1'b0;
    reg_addr   = 4'd0;
    s.s_bvalid = 1'b0;
    s.s_rvalid = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the write goes first unless the write was the last grant.
        if (wr_pend && (!rd_pend || last_rd)) state_next = WRITE;
        else if (rd_pend)                     state_next = READ;
      end
      WRITE: begin
        reg_wen    = wr_ok;
        reg_addr   = aw_addr[5:2];
        state_next = WRESP;
      end
      WRESP: begin
        s.s_bvalid = 1'b1;
        if (s.s_bready) state_next = IDLE;
      end
      READ: begin
        reg_ren    = rd_ok;
        reg_addr   = ar_addr[5:2];
        state_next = RRESP;
      end
      RRESP: begin
        s.s_rvalid = 1'b1;
        if (s.s_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding registers. A register fills when its channel is empty and is freed once the access is serviced.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      ar_held <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
    end else begin
      if (s.s_awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= s.s_awaddr;
      end else if (state == WRITE) begin
        aw_held <= 1'b0;
      end
      if (s.s_wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= s.s_wdata;
      end else if (state == WRITE) begin
        w_held <= 1'b0;
      end
      if (s.s_arvalid && !ar_held) begin
        ar_held <= 1'b1;
        ar_addr <= s.s_araddr;
      end else if (state == READ) begin
        ar_held <= 1'b0;
      end
    end
  end

  // Record the last grant and capture responses in the strobe cycle.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= 1'b1;
      bresp   <= RESP_OKAY;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      if (state == IDLE && state_next == WRITE) last_rd <= 1'b0;
      if (state == IDLE && state_next == READ)  last_rd <= 1'b1;
      if (state == WRITE) bresp <= (wr_ok && !reg_error) ? RESP_OKAY : RESP_SLVERR;
      if (state == READ) begin
        rresp <= (rd_ok && !reg_error) ? RESP_OKAY : RESP_SLVERR;
        rdata <= rd_ok ? reg_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_axil_slave.sv
// Self-checking bench for uart_axil_slave, built with ADDR_WIDTH = 8 so upper address bits are exercised.
// A small register-file model returns the word index as read data and flags index 15 as an error.
module tb_uart_axil_slave;
  localparam int AW = 8;
`ifdef UART_AXIL_STRB_CHECK_EN
  localparam bit STRB_CHECK = 1'b1;
`else
  localparam bit STRB_CHECK = 1'b0;
`endif

  logic        uart_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wen, reg_ren;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic [2:0]  fsm_state;

  uart_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus();

  uart_axil_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .s        (bus.slave),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wen  (reg_wen),
    .reg_ren  (reg_ren),
    .reg_rdata(reg_rdata),
    .reg_error(reg_error),
    .fsm_state(fsm_state)
  );

  // register file model
  assign reg_rdata = {28'h0, reg_addr};
  assign reg_error = (reg_addr == 4'hF);

  // clock / cycle counter
  always #5 uart_clk = ~uart_clk;
  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [35:0] wr_q[$];   // {index, data} expected on reg_wen
  logic [3:0]  rd_q[$];   // index expected on reg_ren
  logic [1:0]  b_q[$];    // expected BRESP
  logic [33:0] r_q[$];    // expected {RRESP, RDATA}
  int wen_cyc = -1, ren_cyc = -1, bv_cyc = -1, rv_cyc = -1, ren_cnt = 0, wen_cnt = 0;
  logic [1:0]  last_bresp, last_rresp;
  logic [31:0] last_rdata;
  logic [2:0]  idle_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expectation model: derived from the address/strobe rules only
  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st);
    int ai;
    logic [3:0] idx;
    logic legal, strobe;
    ai = int'(a);
    idx = 4'(ai / 4);
    legal = (ai % 4 == 0) && (ai < 64);
    strobe = legal && ((st == 4'hF) || !STRB_CHECK);
    if (strobe) wr_q.push_back({idx, d});
    b_q.push_back((!strobe || idx == 4'hF) ? 2'b10 : 2'b00);
  endtask

  task automatic expect_read(input logic [AW-1:0] a);
    int ai;
    logic [3:0] idx;
    ai = int'(a);
    idx = 4'(ai / 4);
    if ((ai % 4 == 0) && (ai < 64)) begin
      rd_q.push_back(idx);
      r_q.push_back({(idx == 4'hF) ? 2'b10 : 2'b00, 28'h0, idx});
    end else begin
      r_q.push_back({2'b10, 32'h0});
    end
  endtask

  // compare process
  logic b_prev = 0, b_stall = 0, r_prev = 0, r_stall = 0;
  logic [1:0]  b_prev_resp;
  logic [33:0] r_prev_pay;
  always @(negedge uart_clk) begin
    if (!rst_n) begin
      wr_q.delete(); rd_q.delete(); b_q.delete(); r_q.delete();
      b_prev = 0; b_stall = 0; r_prev = 0; r_stall = 0;
    end else begin
      check("strobe_exclusive", {reg_wen, reg_ren} == 2'b11, 0);
      if (reg_wen) begin
        wen_cyc = cyc; wen_cnt++;
        if (wr_q.size() == 0) check("unexpected_wen", 1, 0);
        else begin
          logic [35:0] e;
          e = wr_q.pop_front();
          check("wen_addr", reg_addr, e[35:32]);
          check("wen_data", reg_wdata, e[31:0]);
        end
      end
      if (reg_ren) begin
        ren_cyc = cyc; ren_cnt++;
        if (rd_q.size() == 0) check("unexpected_ren", 1, 0);
        else check("ren_addr", reg_addr, rd_q.pop_front());
      end
      if (b_prev && !b_stall) check("bvalid_drop", bus.s_bvalid, 0);
      if (bus.s_bvalid) begin
        if (!b_prev) bv_cyc = cyc;
        if (b_stall) check("bresp_stable", bus.s_bresp, b_prev_resp);
        if (bus.s_bready) begin
          last_bresp = bus.s_bresp;
          if (b_q.size() == 0) check("unexpected_b", 1, 0);
          else check("bresp", bus.s_bresp, b_q.pop_front());
        end
      end
      if (r_prev && !r_stall) check("rvalid_drop", bus.s_rvalid, 0);
      if (bus.s_rvalid) begin
        if (!r_prev) rv_cyc = cyc;
        if (r_stall) check("r_stable", {bus.s_rresp, bus.s_rdata}, r_prev_pay);
        if (bus.s_rready) begin
          last_rresp = bus.s_rresp;
          last_rdata = bus.s_rdata;
          if (r_q.size() == 0) check("unexpected_r", 1, 0);
          else check("r_resp_data", {bus.s_rresp, bus.s_rdata}, r_q.pop_front());
        end
      end
      b_prev = bus.s_bvalid; b_stall = bus.s_bvalid && !bus.s_bready; b_prev_resp = bus.s_bresp;
      r_prev = bus.s_rvalid; r_stall = bus.s_rvalid && !bus.s_rready;
      r_prev_pay = {bus.s_rresp, bus.s_rdata};
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_delay, output int hs);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    aw_done = 0; w_done = 0; n = 0; hs = -1;
    expect_write(a, d, st);
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = st; bus.s_wvalid = 1;
    while (!(aw_done && w_done) && n < 50) begin
      if (n == aw_delay) bus.s_awvalid = 1;
      if (w_done && !aw_done) begin
        check("wready_low_while_held", bus.s_wready, 0);
        check("awready_high_while_empty", bus.s_awready, 1);
      end
      aw_go = bus.s_awvalid && bus.s_awready;
      w_go  = bus.s_wvalid && bus.s_wready;
      if (aw_go || w_go) hs = cyc;
      @(posedge uart_clk); #1;
      if (aw_go) begin bus.s_awvalid = 0; aw_done = 1; end
      if (w_go)  begin bus.s_wvalid = 0;  w_done = 1;  end
      n++;
    end
    check("write_accept_timeout", {aw_done, w_done}, 2'b11);
    bus.s_awvalid = 0; bus.s_wvalid = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int hs);
    int n;
    n = 0; hs = -1;
    expect_read(a);
    bus.s_araddr = a; bus.s_arvalid = 1;
    while (bus.s_arvalid && n < 50) begin
      if (bus.s_arready) begin
        hs = cyc;
        @(posedge uart_clk); #1;
        bus.s_arvalid = 0;
      end else begin
        @(posedge uart_clk); #1;
      end
      n++;
    end
    check("read_accept_timeout", bus.s_arvalid, 0);
    bus.s_arvalid = 0;
  endtask

  // AW, W and AR all presented together into empty holding registers
  task automatic do_tie(input logic [AW-1:0] wa, input logic [31:0] wd, input logic [AW-1:0] ra,
                        output int hs);
    expect_write(wa, wd, 4'hF);
    expect_read(ra);
    bus.s_awaddr = wa; bus.s_wdata = wd; bus.s_wstrb = 4'hF; bus.s_araddr = ra;
    bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_arvalid = 1;
    check("tie_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
    hs = cyc;
    @(posedge uart_clk); #1;
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((wr_q.size() + rd_q.size() + b_q.size() + r_q.size()) != 0 && n < 100) begin
      @(posedge uart_clk); #1;
      n++;
    end
    check("drain_timeout", n >= 100, 0);
    repeat (2) @(posedge uart_clk);
    #1;
    check("fsm_back_idle", fsm_state, idle_code);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // directed sequence
  initial begin
    int hs, rc;
    rst_n = 0;
    bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 0;
    bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_bready = 1; bus.s_rready = 1;
    repeat (3) @(posedge uart_clk);
    #1;
    check("rst_bvalid", bus.s_bvalid, 0);
    check("rst_rvalid", bus.s_rvalid, 0);
    check("rst_strobes", {reg_wen, reg_ren}, 2'b00);
    check("rst_resps", {bus.s_bresp, bus.s_rresp}, 4'b0000);
    check("rst_rdata", bus.s_rdata, 32'h0);
    rst_n = 1;
    #1;
    check("rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
    idle_code = fsm_state;
    @(posedge uart_clk); #1;

    // write 0x3 to 0x00, AW and W together
    do_write(8'h00, 32'h3, 4'hF, 0, hs);
    wait_drain();
    check("w1_wen_cycle", wen_cyc, hs + 2);
    check("w1_bvalid_cycle", bv_cyc, hs + 3);
    check("w1_bresp", last_bresp, 2'b00);

    // W first, AW three cycles later
    do_write(8'h00, 32'hCAFEF00D, 4'hF, 3, hs);
    wait_drain();
    check("w2_wen_cycle", wen_cyc, hs + 2);

    // read 0x10 with the response held off for 3 cycles
    bus.s_rready = 0;
    do_read(8'h10, hs);
    rc = 0;
    while (!bus.s_rvalid && rc < 20) begin @(posedge uart_clk); #1; rc++; end
    check("r1_rvalid_seen", bus.s_rvalid, 1);
    repeat (3) @(posedge uart_clk);
    #1;
    bus.s_rready = 1;
    wait_drain();
    check("r1_ren_cycle", ren_cyc, hs + 2);
    check("r1_rvalid_cycle", rv_cyc, hs + 3);
    check("r1_rdata", last_rdata, 32'h4);
    check("r1_rresp", last_rresp, 2'b00);

    // misaligned read: no strobe, SLVERR, zero data
    rc = ren_cnt;
    do_read(8'h0E, hs);
    wait_drain();
    check("r2_no_ren", ren_cnt, rc);
    check("r2_rresp", last_rresp, 2'b10);
    check("r2_rdata", last_rdata, 32'h0);

    // partial-strobe write
    rc = wen_cnt;
    do_write(8'h08, 32'h55, 4'h1, 0, hs);
    wait_drain();
    check("w3_bresp", last_bresp, STRB_CHECK ? 2'b10 : 2'b00);
    check("w3_wen_count", wen_cnt, STRB_CHECK ? rc : rc + 1);

    // error index, out-of-window addresses, and an upper word index
    do_write(8'h3C, 32'h12345678, 4'hF, 0, hs);
    wait_drain();
    check("w4_bresp_regerror", last_bresp, 2'b10);
    do_read(8'h3C, hs);
    wait_drain();
    check("r3_rdata_regerror", last_rdata, 32'hF);
    check("r3_rresp_regerror", last_rresp, 2'b10);
    rc = wen_cnt;
    do_write(8'h40, 32'hDEAD, 4'hF, 0, hs);
    wait_drain();
    check("w5_no_wen_upper", wen_cnt, rc);
    check("w5_bresp_upper", last_bresp, 2'b10);
    do_read(8'h80, hs);
    wait_drain();
    check("r4_rresp_upper", last_rresp, 2'b10);
    do_read(8'h20, hs);
    wait_drain();
    check("r5_rdata_idx8", last_rdata, 32'h8);

    // tie after a read grant: write first
    do_tie(8'h14, 32'hA5A50001, 8'h18, hs);
    wait_drain();
    check("tie1_wen_cycle", wen_cyc, hs + 2);
    check("tie1_ren_cycle", ren_cyc, hs + 5);

    // tie after a write grant: read first
    do_write(8'h1C, 32'h77, 4'hF, 0, hs);
    wait_drain();
    do_tie(8'h24, 32'hA5A50002, 8'h28, hs);
    wait_drain();
    check("tie2_ren_cycle", ren_cyc, hs + 2);
    check("tie2_wen_cycle", wen_cyc, hs + 5);

    // reset while in WRITE
    bus.s_awaddr = 8'h04; bus.s_wdata = 32'hBADBAD; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1; bus.s_wvalid = 1;
    @(posedge uart_clk); #1;
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    @(posedge uart_clk); #1;
    check("rst_mid_wen_before", reg_wen, 1);
    rst_n = 0;
    #1;
    check("rst_mid_wen_gone", reg_wen, 0);
    check("rst_mid_bvalid", bus.s_bvalid, 0);
    repeat (2) @(posedge uart_clk);
    #1;
    rst_n = 1;
    #1;
    check("rst_mid_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);
    for (int i = 0; i < 8; i++) begin
      @(posedge uart_clk); #1;
      check("rst_mid_quiet", {bus.s_bvalid, bus.s_rvalid, reg_wen, reg_ren}, 4'b0000);
    end

    // traffic after reset
    do_write(8'h0C, 32'h0BADF00D, 4'hF, 0, hs);
    wait_drain();
    check("post_rst_wen_cycle", wen_cyc, hs + 2);
    do_read(8'h0C, hs);
    wait_drain();
    check("post_rst_rdata", last_rdata, 32'h3);

    check("final_queues_empty", wr_q.size() + rd_q.size() + b_q.size() + r_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
